slavefifo2b_mode_ctrl: RTL and testbench
========================================

Name: slavefifo2b_mode_ctrl

Overview:
- Mode controller and interface arbiter for the FX3 Slave FIFO 2-bit bus.
- Owns the single FPGA-side GPIF II pin set and hands it to exactly one traffic generator: loopback, stream-IN, stream-OUT or ZLP.
- Drives each generator's mode_selected input.
- Muxes the active generator's strobes and data onto the pins.
- Sequences mode changes so the bus is quiet before ownership moves.

Parameters:
- QUIET_CYCLES, 4: consecutive idle-strobe cycles required in DRAIN before a switch.
- SETTLE_CYCLES, 8: cycles held in SWITCH with all generators deselected.
- REQ_STABLE, 3: consecutive cycles mode_req must hold a new value before it is accepted.

Ports:
- clk_100  in  1  system clock, 100 MHz
- reset_  in  1  asynchronous active-low reset
- mode_req  in  3  requested mode: 0 idle, 1 loopback, 2 stream_in, 3 stream_out, 4 zlp; values 5-7 are treated as 0
- slwr_lb_, slwr_sin_, slwr_zlp_  in  1 each  generator write strobes, active-low
- slrd_lb_, slrd_sout_  in  1 each  generator read strobes, active-low
- sloe_lb_, sloe_sout_  in  1 each  generator output enables, active-low
- pktend_lb_, pktend_sin_, pktend_zlp_  in  1 each  generator packet-end strobes, active-low
- faddr_lb  in  2  loopback FIFO address
- data_lb, data_sin, data_zlp  in  32 each  generator write data
- lb_sel, sin_sel, sout_sel, zlp_sel  out  1 each  mode_selected to each generator
- slwr_, slrd_, sloe_, pktend_  out  1 each  muxed bus strobes, active-low
- faddr  out  2  muxed FIFO address
- data_out  out  32  muxed write data
- active_mode  out  3  currently granted mode
- busy  out  1  high in DRAIN or SWITCH

Behaviour:
- Reset values:
  - state IDLE, active_mode 0, all *_sel 0
  - slwr_, slrd_, sloe_, pktend_ = 1; faddr = 0; data_out = 0; busy = 0
  - internal counters 0
- Request filter:
  - mode_req is registered once to give req_q (invalid codes 5-7 map to 0).
  - stab_cnt increments while req_q equals the previous req_q and differs from active_mode; otherwise it clears.
  - A new request is pending when stab_cnt reaches REQ_STABLE-1. target is latched at that moment.
- FSM states IDLE, ACTIVE, DRAIN, SWITCH:
  - IDLE: active_mode = 0; pending request → SWITCH.
  - ACTIVE: the *_sel matching active_mode is 1, all others 0. Pending request → DRAIN, and all *_sel drop on the same edge.
  - DRAIN: quiet_cnt counts consecutive cycles in which every generator slwr_/slrd_/pktend_ input is 1; any low clears it. quiet_cnt reaching QUIET_CYCLES-1 → SWITCH.
  - SWITCH: active_mode <= target on entry; set_cnt counts up to SETTLE_CYCLES-1. On completion → ACTIVE if target ≠ 0, else IDLE.
  - A new request arriving in DRAIN or SWITCH updates target only. It takes effect at the next SWITCH entry, or at SWITCH exit if the request arrives after entry, in which case the FSM re-enters SWITCH.
- Output mux:
  - Combinational from registered state/active_mode; zero-cycle latency from generator to pin.
  - Outside ACTIVE, all strobes are 1, data_out = 0 and faddr holds its last value.
  - ACTIVE, loopback: all lb signals pass through, faddr = faddr_lb.
  - ACTIVE, stream_in: slwr_sin_, pktend_sin_, data_sin pass through; faddr = 2'b00; slrd_ = sloe_ = 1.
  - ACTIVE, stream_out: slrd_sout_, sloe_sout_ pass through; faddr = 2'b11; slwr_ = pktend_ = 1.
  - ACTIVE, zlp: slwr_zlp_, pktend_zlp_, data_zlp pass through; faddr = 2'b00.
- Invariants:
  - At most one *_sel is high at any time.
  - sloe_ = 0 and slwr_ = 0 never occur in the same cycle. If a generator violates this, slwr_ is forced to 1.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronously).

Decomposition:
- Shared package slavefifo2b_pkg holds:
  - mode codes MODE_IDLE..MODE_ZLP
  - FSM state encodings
  - FIFO address constants FADDR_PROD = 2'b00, FADDR_CONS = 2'b11
- One sub-module, slavefifo2b_req_filter: the req_q register and stab_cnt stability counter, with outputs pending and target.

Test Plan:
- Reset, then mode_req = 2 held → SWITCH entered on cycle 4 after req; sin_sel = 1 after 8 settle cycles; slwr_ follows slwr_sin_ with 0 latency; faddr = 00.
- Active stream_in, generator slwr_ low continuously, mode_req → 3 → FSM stays in DRAIN and busy = 1 until slwr_sin_ is 1 for 4 cycles; then sout_sel = 1 and faddr = 11.
- mode_req glitches to 4 for 2 cycles, then back → no state change; active_mode unchanged.
- mode_req = 7 while ACTIVE loopback → drain, switch, reach IDLE; all *_sel = 0; strobes stay 1.
- During SWITCH to 4, mode_req changes to 1 → FSM re-enters SWITCH and finishes with lb_sel = 1 and zlp_sel never asserted.
- Loopback generator drives sloe_lb_ = 0 and slwr_lb_ = 0 together → slwr_ = 1 and sloe_ = 0; reset_ pulsed mid-ACTIVE → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/slavefifo2b_pkg.sv
// Shared definitions for the FX3 Slave FIFO 2-bit mode controller.
// Holds the mode codes, the FSM state encoding, the FIFO address constants,
// and a helper that folds unsupported mode_req codes onto idle.
package slavefifo2b_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_LB   = 3'd1,
    MODE_SIN  = 3'd2,
    MODE_SOUT = 3'd3,
    MODE_ZLP  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;

  // Producer socket for FPGA writes, consumer socket for FPGA reads
  localparam logic [1:0] FADDR_PROD = 2'b00;
  localparam logic [1:0] FADDR_CONS = 2'b11;

  // Codes 5-7 have no generator behind them and are treated as idle
  function automatic mode_e sanitize_mode(input logic [2:0] code);
    mode_e m;
    case (code)
      3'd1:    m = MODE_LB;
      3'd2:    m = MODE_SIN;
      3'd3:    m = MODE_SOUT;
      3'd4:    m = MODE_ZLP;
      default: m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/slavefifo2b_req_filter.sv
// Request filter for the mode controller.
// Registers mode_req once (invalid codes folded to idle) and only reports a
// request once the registered value has held steady and differs from the
// currently granted mode.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_mode_req         raw requested mode code
//   i_active_mode      currently granted mode
//   o_pending          one-cycle pulse: a new stable request was accepted
//   o_target           latest accepted mode (already valid in the pulse cycle)
module slavefifo2b_req_filter
  import slavefifo2b_pkg::*;
#(
  parameter int REQ_STABLE = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_mode_req,
  input  mode_e      i_active_mode,
  output logic       o_pending,
  output mode_e      o_target
);

  localparam int SW = (REQ_STABLE > 2) ? $clog2(REQ_STABLE) : 1;

  mode_e         r_req_q;
  mode_e         r_req_prev;
  mode_e         r_target;
  logic [SW-1:0] r_stab_cnt;
  logic          w_same;

  assign w_same = (r_req_q == r_req_prev) && (r_req_q != i_active_mode);

  // Pulse on the edge where the counter reaches REQ_STABLE-1; it then
  // saturates so a request that keeps holding is not re-announced.
  assign o_pending = w_same && (r_stab_cnt == SW'(REQ_STABLE - 2));

  // Bypass so the FSM can act on the target in the same cycle it is accepted
  assign o_target = o_pending ? r_req_q : r_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_q    <= MODE_IDLE;
      r_req_prev <= MODE_IDLE;
      r_target   <= MODE_IDLE;
      r_stab_cnt <= '0;
    end else begin
      r_req_q    <= sanitize_mode(i_mode_req);
      r_req_prev <= r_req_q;
      if (!w_same) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != SW'(REQ_STABLE - 1)) begin
        r_stab_cnt <= r_stab_cnt + SW'(1);
      end
      if (o_pending) begin
        r_target <= r_req_q;
      end
    end
  end

endmodule

// File: rtl/slavefifo2b_mode_ctrl.sv
// Mode controller and GPIF II pin arbiter for the FX3 Slave FIFO 2-bit bus.
// Grants the single FPGA-side pin set to one traffic generator (loopback,
// stream-IN, stream-OUT, ZLP), drives each generator's mode_selected, and
// sequences ownership changes through DRAIN (bus quiet) and SWITCH (settle).
// Ports:
//   clk_100, reset_                 clock, asynchronous active-low reset
//   mode_req                        requested mode (5-7 treated as idle)
//   slwr_*/slrd_*/sloe_*/pktend_*   generator strobes, active-low
//   faddr_lb, data_*                generator address / write data
//   lb_sel..zlp_sel                 mode_selected to each generator
//   slwr_, slrd_, sloe_, pktend_    muxed bus strobes, active-low
//   faddr, data_out                 muxed FIFO address and write data
//   active_mode                     currently granted mode
//   busy                            high in DRAIN or SWITCH
module slavefifo2b_mode_ctrl
  import slavefifo2b_pkg::*;
#(
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int REQ_STABLE    = 3
) (
  input  logic              clk_100,
  input  logic              reset_,
  input  logic [2:0]        mode_req,
  input  logic              slwr_lb_,
  input  logic              slwr_sin_,
  input  logic              slwr_zlp_,
  input  logic              slrd_lb_,
  input  logic              slrd_sout_,
  input  logic              sloe_lb_,
  input  logic              sloe_sout_,
  input  logic              pktend_lb_,
  input  logic              pktend_sin_,
  input  logic              pktend_zlp_,
  input  logic [1:0]        faddr_lb,
  input  logic [DATA_W-1:0] data_lb,
  input  logic [DATA_W-1:0] data_sin,
  input  logic [DATA_W-1:0] data_zlp,
  output logic              lb_sel,
  output logic              sin_sel,
  output logic              sout_sel,
  output logic              zlp_sel,
  output logic              slwr_,
  output logic              slrd_,
  output logic              sloe_,
  output logic              pktend_,
  output logic [1:0]        faddr,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        active_mode,
  output logic              busy
);

  localparam int QW = (QUIET_CYCLES > 2)  ? $clog2(QUIET_CYCLES)  : 1;
  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  mode_e             r_active_mode;
  logic [QW-1:0]     r_quiet_cnt;
  logic [CW-1:0]     r_set_cnt;
  logic [1:0]        r_faddr_last;

  logic              w_pending;
  mode_e             w_target;
  logic              w_quiet;
  logic              w_quiet_done;
  logic              w_settle_done;
  logic              w_enter_switch;

  logic              w_slwr;
  logic              w_slrd;
  logic              w_sloe;
  logic              w_pktend;
  logic [1:0]        w_faddr;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_sel;

  slavefifo2b_req_filter #(
    .REQ_STABLE (REQ_STABLE)
  ) u_req_filter (
    .i_clk         (clk_100),
    .i_rst_n       (reset_),
    .i_mode_req    (mode_req),
    .i_active_mode (r_active_mode),
    .o_pending     (w_pending),
    .o_target      (w_target)
  );

  // sloe_ is not a bus-driving strobe, so it does not block the drain
  assign w_quiet = slwr_lb_ & slwr_sin_ & slwr_zlp_ & slrd_lb_ & slrd_sout_ &
                   pktend_lb_ & pktend_sin_ & pktend_zlp_;

  assign w_quiet_done  = (r_state == ST_DRAIN) && w_quiet &&
                         (r_quiet_cnt == QW'(QUIET_CYCLES - 1));
  assign w_settle_done = (r_state == ST_SWITCH) &&
                         (r_set_cnt == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A request accepted after SWITCH entry leaves target != active_mode at
  // the end of settling; the FSM then restarts SWITCH with the new target.
  always_comb begin
    w_state_nxt    = r_state;
    w_enter_switch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_state_nxt    = ST_SWITCH;
          w_enter_switch = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_pending) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_quiet_done) begin
          w_state_nxt    = ST_SWITCH;
          w_enter_switch = 1'b1;
        end
      end
      ST_SWITCH: begin
        if (w_settle_done) begin
          if (w_target != r_active_mode) begin
            w_enter_switch = 1'b1;
          end else if (w_target == MODE_IDLE) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ACTIVE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      r_active_mode <= MODE_IDLE;
      r_quiet_cnt   <= '0;
      r_set_cnt     <= '0;
      r_faddr_last  <= '0;
    end else begin
      if (w_enter_switch) begin
        r_active_mode <= w_target;
      end
      if ((r_state == ST_DRAIN) && w_quiet && !w_quiet_done) begin
        r_quiet_cnt <= r_quiet_cnt + QW'(1);
      end else begin
        r_quiet_cnt <= '0;
      end
      if ((r_state == ST_SWITCH) && !w_settle_done) begin
        r_set_cnt <= r_set_cnt + CW'(1);
      end else begin
        r_set_cnt <= '0;
      end
      // Remembers the last driven address so faddr holds outside ACTIVE
      r_faddr_last <= w_faddr;
    end
  end

  always_comb begin
    w_sel    = 4'b0000;
    w_slwr   = 1'b1;
    w_slrd   = 1'b1;
    w_sloe   = 1'b1;
    w_pktend = 1'b1;
    w_data   = '0;
    w_faddr  = r_faddr_last;
    if (r_state == ST_ACTIVE) begin
      case (r_active_mode)
        MODE_LB: begin
          w_sel    = 4'b0001;
          w_slwr   = slwr_lb_;
          w_slrd   = slrd_lb_;
          w_sloe   = sloe_lb_;
          w_pktend = pktend_lb_;
          w_data   = data_lb;
          w_faddr  = faddr_lb;
        end
        MODE_SIN: begin
          w_sel    = 4'b0010;
          w_slwr   = slwr_sin_;
          w_pktend = pktend_sin_;
          w_data   = data_sin;
          w_faddr  = FADDR_PROD;
        end
        MODE_SOUT: begin
          w_sel    = 4'b0100;
          w_slrd   = slrd_sout_;
          w_sloe   = sloe_sout_;
          w_faddr  = FADDR_CONS;
        end
        MODE_ZLP: begin
          w_sel    = 4'b1000;
          w_slwr   = slwr_zlp_;
          w_pktend = pktend_zlp_;
          w_data   = data_zlp;
          w_faddr  = FADDR_PROD;
        end
        default: ;
      endcase
    end
  end

  assign lb_sel      = w_sel[0];
  assign sin_sel     = w_sel[1];
  assign sout_sel    = w_sel[2];
  assign zlp_sel     = w_sel[3];
  // FX3 drives the data bus while sloe_ is low, so a write then would contend
  assign slwr_       = w_slwr | ~w_sloe;
  assign slrd_       = w_slrd;
  assign sloe_       = w_sloe;
  assign pktend_     = w_pktend;
  assign faddr       = w_faddr;
  assign data_out    = w_data;
  assign active_mode = r_active_mode;
  assign busy        = (r_state == ST_DRAIN) || (r_state == ST_SWITCH);

endmodule

// File: tb/tb_slavefifo2b_mode_ctrl.sv
// Testbench for slavefifo2b_mode_ctrl: directed scenarios plus randomized
// mode requests and generator activity, compared every cycle against a
// behavioural model of the granting rules.
module tb_slavefifo2b_mode_ctrl;

  localparam int QUIET_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 8;
  localparam int REQ_STABLE    = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_ACT   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_SW    = 3;

  logic        clk_100 = 1'b0;
  logic        reset_;
  logic [2:0]  mode_req;
  logic        slwr_lb_, slwr_sin_, slwr_zlp_, slrd_lb_, slrd_sout_;
  logic        sloe_lb_, sloe_sout_, pktend_lb_, pktend_sin_, pktend_zlp_;
  logic [1:0]  faddr_lb;
  logic [31:0] data_lb, data_sin, data_zlp;
  logic        lb_sel, sin_sel, sout_sel, zlp_sel;
  logic        slwr_, slrd_, sloe_, pktend_;
  logic [1:0]  faddr;
  logic [31:0] data_out;
  logic [2:0]  active_mode;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit zlp_seen = 1'b0;

  // Model state
  int         m_phase, m_mode, m_target, samp_q, samp_prev, run;
  int         quiet_run, settle_left;
  logic [1:0] m_faddr_hold;

  slavefifo2b_mode_ctrl #(
    .QUIET_CYCLES  (QUIET_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .REQ_STABLE    (REQ_STABLE)
  ) dut (
    .clk_100     (clk_100),
    .reset_      (reset_),
    .mode_req    (mode_req),
    .slwr_lb_    (slwr_lb_),
    .slwr_sin_   (slwr_sin_),
    .slwr_zlp_   (slwr_zlp_),
    .slrd_lb_    (slrd_lb_),
    .slrd_sout_  (slrd_sout_),
    .sloe_lb_    (sloe_lb_),
    .sloe_sout_  (sloe_sout_),
    .pktend_lb_  (pktend_lb_),
    .pktend_sin_ (pktend_sin_),
    .pktend_zlp_ (pktend_zlp_),
    .faddr_lb    (faddr_lb),
    .data_lb     (data_lb),
    .data_sin    (data_sin),
    .data_zlp    (data_zlp),
    .lb_sel      (lb_sel),
    .sin_sel     (sin_sel),
    .sout_sel    (sout_sel),
    .zlp_sel     (zlp_sel),
    .slwr_       (slwr_),
    .slrd_       (slrd_),
    .sloe_       (sloe_),
    .pktend_     (pktend_),
    .faddr       (faddr),
    .data_out    (data_out),
    .active_mode (active_mode),
    .busy        (busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int san(input logic [2:0] v);
    return (v > 3'd4) ? 0 : int'(v);
  endfunction

  task automatic model_reset();
    m_phase      = PH_IDLE;
    m_mode       = 0;
    m_target     = 0;
    samp_q       = 0;
    samp_prev    = 0;
    run          = 0;
    quiet_run    = 0;
    settle_left  = 0;
    m_faddr_hold = 2'b00;
  endtask

  // Expected pins: sel = {lb,sin,sout,zlp}, st = {slwr_,slrd_,sloe_,pktend_}
  task automatic model_outputs(output logic [3:0] sel, output logic [3:0] st,
                               output logic [1:0] fa, output logic [31:0] d);
    sel = 4'b0000;
    st  = 4'b1111;
    fa  = m_faddr_hold;
    d   = 32'h0;
    if (m_phase == PH_ACT) begin
      case (m_mode)
        1: begin
          sel = 4'b1000;
          st  = {slwr_lb_, slrd_lb_, sloe_lb_, pktend_lb_};
          if (!sloe_lb_) st[3] = 1'b1;
          fa  = faddr_lb;
          d   = data_lb;
        end
        2: begin
          sel = 4'b0100;
          st  = {slwr_sin_, 1'b1, 1'b1, pktend_sin_};
          fa  = 2'b00;
          d   = data_sin;
        end
        3: begin
          sel = 4'b0010;
          st  = {1'b1, slrd_sout_, sloe_sout_, 1'b1};
          fa  = 2'b11;
        end
        4: begin
          sel = 4'b0001;
          st  = {slwr_zlp_, 1'b1, 1'b1, pktend_zlp_};
          fa  = 2'b00;
          d   = data_zlp;
        end
        default: ;
      endcase
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it
  task automatic model_step();
    logic [3:0]  sel, st;
    logic [1:0]  fa;
    logic [31:0] d;
    bit cond, accept, quiet, enter;
    int tgt, run_n;
    model_outputs(sel, st, fa, d);
    cond   = (samp_q == samp_prev) && (samp_q != m_mode);
    accept = cond && (run == REQ_STABLE - 2);
    tgt    = accept ? samp_q : m_target;
    run_n  = cond ? ((run < REQ_STABLE - 1) ? run + 1 : run) : 0;
    quiet  = slwr_lb_ & slwr_sin_ & slwr_zlp_ & slrd_lb_ & slrd_sout_ &
             pktend_lb_ & pktend_sin_ & pktend_zlp_;
    enter  = 1'b0;
    case (m_phase)
      PH_IDLE: if (accept) enter = 1'b1;
      PH_ACT: begin
        if (accept) begin
          m_phase   = PH_DRAIN;
          quiet_run = 0;
        end
      end
      PH_DRAIN: begin
        quiet_run = quiet ? quiet_run + 1 : 0;
        if (quiet_run == QUIET_CYCLES) enter = 1'b1;
      end
      default: begin
        settle_left--;
        if (settle_left == 0) begin
          if (tgt != m_mode) enter = 1'b1;
          else m_phase = (tgt == 0) ? PH_IDLE : PH_ACT;
        end
      end
    endcase
    if (enter) begin
      m_phase     = PH_SW;
      m_mode      = tgt;
      settle_left = SETTLE_CYCLES;
    end
    m_faddr_hold = fa;
    samp_prev    = samp_q;
    samp_q       = san(mode_req);
    m_target     = tgt;
    run          = run_n;
  endtask

  task automatic check_outputs();
    logic [3:0]  sel, st;
    logic [1:0]  fa;
    logic [31:0] d;
    model_outputs(sel, st, fa, d);
    chk("sel",         32'({lb_sel, sin_sel, sout_sel, zlp_sel}), 32'(sel));
    chk("strobes",     32'({slwr_, slrd_, sloe_, pktend_}), 32'(st));
    chk("faddr",       32'(faddr), 32'(fa));
    chk("data_out",    data_out, d);
    chk("active_mode", 32'(active_mode), 32'(m_mode));
    chk("busy",        32'(busy), 32'((m_phase == PH_DRAIN) || (m_phase == PH_SW)));
    if (zlp_sel) zlp_seen = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"},     32'({lb_sel, sin_sel, sout_sel, zlp_sel}), 32'h0);
    chk({tag, "_strobes"}, 32'({slwr_, slrd_, sloe_, pktend_}), 32'hF);
    chk({tag, "_faddr"},   32'(faddr), 32'h0);
    chk({tag, "_data"},    data_out, 32'h0);
    chk({tag, "_mode"},    32'(active_mode), 32'h0);
    chk({tag, "_busy"},    32'(busy), 32'h0);
  endtask

  // Inputs change at posedge+1, outputs are compared at posedge+3
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #2;
      check_outputs();
      @(posedge clk_100);
      model_step();
      #1;
    end
  endtask

  task automatic quiet_gens();
    {slwr_lb_, slwr_sin_, slwr_zlp_, slrd_lb_, slrd_sout_} = 5'h1F;
    {sloe_lb_, sloe_sout_, pktend_lb_, pktend_sin_, pktend_zlp_} = 5'h1F;
  endtask

  task automatic rand_gens(input int active_pct);
    if ($urandom_range(99) < active_pct) begin
      {slwr_lb_, slwr_sin_, slwr_zlp_, slrd_lb_, slrd_sout_,
       pktend_lb_, pktend_sin_, pktend_zlp_} = 8'($urandom | $urandom);
    end else begin
      {slwr_lb_, slwr_sin_, slwr_zlp_, slrd_lb_, slrd_sout_,
       pktend_lb_, pktend_sin_, pktend_zlp_} = 8'hFF;
    end
    {sloe_lb_, sloe_sout_} = 2'($urandom);
    faddr_lb = 2'($urandom);
    data_lb  = $urandom;
    data_sin = $urandom;
    data_zlp = $urandom;
  endtask

  initial begin
    reset_   = 1'b0;
    mode_req = 3'd0;
    faddr_lb = 2'b01;
    data_lb  = 32'h1111_0000;
    data_sin = 32'h2222_0000;
    data_zlp = 32'h4444_0000;
    quiet_gens();
    model_reset();
    repeat (3) @(posedge clk_100);
    #1;
    chk_reset_vals("por");
    reset_ = 1'b1;

    // stream_in from idle: SWITCH after 4 edges, granted after 8 more
    mode_req = 3'd2;
    cycles(4);
    chk("s1_busy_at_switch", 32'(busy), 32'd1);
    cycles(7);
    chk("s1_sin_sel_settling", 32'(sin_sel), 32'd0);
    cycles(1);
    chk("s1_sin_sel_granted", 32'(sin_sel), 32'd1);
    slwr_sin_ = 1'b0;
    data_sin  = 32'hA5A5_0001;
    #1;
    chk("s1_slwr_pass", 32'(slwr_), 32'd0);
    chk("s1_faddr", 32'(faddr), 32'd0);
    chk("s1_data", data_out, 32'hA5A5_0001);

    // stream_out request while stream_in keeps writing: held in DRAIN
    mode_req = 3'd3;
    cycles(20);
    chk("s2_busy_drain", 32'(busy), 32'd1);
    chk("s2_mode_kept", 32'(active_mode), 32'd2);
    chk("s2_sout_sel_wait", 32'(sout_sel), 32'd0);
    slwr_sin_ = 1'b1;
    cycles(11);
    chk("s2_sout_sel_settling", 32'(sout_sel), 32'd0);
    cycles(1);
    chk("s2_sout_sel_granted", 32'(sout_sel), 32'd1);
    chk("s2_faddr_cons", 32'(faddr), 32'd3);

    // two-cycle glitch to zlp is ignored
    mode_req = 3'd4;
    cycles(2);
    mode_req = 3'd3;
    cycles(10);
    chk("s3_mode_unchanged", 32'(active_mode), 32'd3);
    chk("s3_not_busy", 32'(busy), 32'd0);

    // loopback, then write/oe conflict forces slwr_ high
    mode_req = 3'd1;
    cycles(30);
    chk("s4_lb_sel", 32'(lb_sel), 32'd1);
    slwr_lb_ = 1'b0;
    sloe_lb_ = 1'b0;
    #1;
    chk("s4_conflict_slwr", 32'(slwr_), 32'd1);
    chk("s4_conflict_sloe", 32'(sloe_), 32'd0);
    quiet_gens();

    // invalid code 7 returns to idle
    mode_req = 3'd7;
    cycles(30);
    chk("s5_idle_mode", 32'(active_mode), 32'd0);
    chk("s5_idle_sel", 32'({lb_sel, sin_sel, sout_sel, zlp_sel}), 32'd0);
    slwr_lb_ = 1'b0;
    slrd_lb_ = 1'b0;
    #1;
    chk("s5_idle_strobes", 32'({slwr_, slrd_, sloe_, pktend_}), 32'hF);
    quiet_gens();

    // retarget during SWITCH: zlp never granted, ends in loopback
    zlp_seen = 1'b0;
    mode_req = 3'd4;
    cycles(5);
    mode_req = 3'd1;
    cycles(30);
    chk("s6_lb_sel", 32'(lb_sel), 32'd1);
    chk("s6_zlp_never", 32'(zlp_seen), 32'd0);

    // asynchronous reset mid-ACTIVE
    slwr_lb_ = 1'b0;
    pktend_lb_ = 1'b0;
    #2;
    reset_ = 1'b0;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    quiet_gens();
    mode_req = 3'd0;
    @(posedge clk_100);
    #1;
    reset_ = 1'b1;
    cycles(3);

    // randomized requests and generator activity
    for (int seg = 0; seg < 150; seg++) begin
      int len, pct;
      mode_req = 3'($urandom_range(7));
      len = $urandom_range(1, 40);
      pct = $urandom_range(0, 80);
      for (int i = 0; i < len; i++) begin
        rand_gens(pct);
        cycles(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
